// File: rtl/cla_div_pkg.sv
// Shared types and constants for the CLA-based sequential divider.
// Slice width is fixed at 4 bits; operand widths must be a multiple of it.
package cla_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int slice_cnt(input int w);
        return w / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// WIDTH-bit a-b from chained 4-bit carry look-ahead slices.
// b is inverted and carry-in is 1; cout=1 means no borrow.
module cla_subtractor
    import cla_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             cout
);

    localparam int NS = slice_cnt(WIDTH);

    logic [NS:0]      c;
    logic [WIDTH-1:0] bn;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    assign c[0] = 1'b1;
    assign bn   = ~b;
    assign g    = a & bn;
    assign p    = a ^ bn;

    for (genvar s = 0; s < NS; s++) begin : g_slice
        localparam int B = s * SLICE_W;
        logic [SLICE_W:0] k;

        assign k[0] = c[s];
        assign k[1] = g[B]
                    | (p[B] & c[s]);
        assign k[2] = g[B+1]
                    | (p[B+1] & g[B])
                    | (p[B+1] & p[B] & c[s]);
        assign k[3] = g[B+2]
                    | (p[B+2] & g[B+1])
                    | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & c[s]);
        assign k[4] = g[B+3]
                    | (p[B+3] & g[B+2])
                    | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B])
                    | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[s]);

        assign diff[B +: SLICE_W] = p[B +: SLICE_W] ^ k[SLICE_W-1:0];
        assign c[s+1] = k[SLICE_W];
    end

    assign cout = c[NS];

endmodule

// File: rtl/cla_seq_divider.sv
// Restoring divider, one quotient bit per clock, start/done handshake.
// Define CLA_DIV_SIGNED_EN for two's-complement operands.
module cla_seq_divider
    import cla_div_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qsr;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             zero;
    logic             last;

    assign zero    = (divisor == '0);
    assign last    = (cnt == CNT_W'(1));
    assign shifted = {rem, dsr[WIDTH-1]};
    assign take    = shifted[WIDTH] | cout;
    assign rem_nxt = take ? diff : shifted[WIDTH-1:0];
    assign q_nxt   = {qsr[WIDTH-2:0], take};

    cla_subtractor #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a    (shifted[WIDTH-1:0]),
        .b    (dvs),
        .diff (diff),
        .cout (cout)
    );

`ifdef CLA_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Magnitudes at acceptance; sign fix-up applied to the final step.
    always_comb begin
        mag_a = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        mag_b = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
        q_fin = neg_q ? (~q_nxt + 1'b1) : q_nxt;
        r_fin = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
    end

    // Sign flags captured with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    // Unsigned build passes values straight through.
    always_comb begin
        mag_a = dividend;
        mag_b = divisor;
        q_fin = q_nxt;
        r_fin = rem_nxt;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = zero ? DONE : CALC;
            CALC:    if (last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dsr         <= '0;
            dvs         <= '0;
            rem         <= '0;
            qsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && zero) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        dsr         <= mag_a;
                        dvs         <= mag_b;
                        rem         <= '0;
                        qsr         <= '0;
                        cnt         <= CNT_W'(WIDTH);
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    qsr <= q_nxt;
                    dsr <= {dsr[WIDTH-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_divider.sv
// Directed vectors, handshake corner cases and a random sweep.
// Expected values come from tables and an integer reference model.
module tb_cla_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int ncmp;
    int nfail;

    cla_seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Issue one division; optionally hold start high until done.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit hold,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output int edges,
                           output int busyc);
        bit seen;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        edges    = 0;
        busyc    = 0;
        seen     = 0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (!hold) start = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            if (busy) busyc++;
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) begin
            nfail++;
            ncmp++;
            $display("FAIL timeout: got no done want done");
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);
        chk("busy_drop", busy, 0);
        chk("q_held", quotient, q);
    endtask

    function automatic void model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] q,
                                  output logic [W-1:0] r);
        int sa;
        int sb;
`ifdef CLA_DIV_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        sa = int'(a);
        sb = int'(b);
`endif
        if (sb == 0) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    vec_t         tbl[$];
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           e;
    int           bc;
    int           nd;

    initial begin
        ncmp     = 0;
        nfail    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

`ifdef CLA_DIV_SIGNED_EN
        tbl.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9});
        tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9});
        tbl.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9});
        tbl.push_back('{8'hDB, 8'h05, 8'hF9, 8'hFE, 1'b0, 9});
        tbl.push_back('{8'd37, 8'd0,  8'hFF, 8'd37, 1'b1, 1});
        tbl.push_back('{8'd37, 8'd5,  8'd7,  8'd2,  1'b0, 9});
        tbl.push_back('{8'd100, 8'd7, 8'd14, 8'd2,  1'b0, 9});
`else
        tbl.push_back('{8'd200, 8'd7, 8'd28, 8'd4,  1'b0, 9});
        tbl.push_back('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9});
        tbl.push_back('{8'd5,  8'd9,  8'd0,  8'd5,  1'b0, 9});
        tbl.push_back('{8'd37, 8'd0,  8'd255, 8'd37, 1'b1, 1});
        tbl.push_back('{8'd37, 8'd5,  8'd7,  8'd2,  1'b0, 9});
        tbl.push_back('{8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9});
        tbl.push_back('{8'd0,  8'd3,  8'd0,  8'd0,  1'b0, 9});
        tbl.push_back('{8'd254, 8'd16, 8'd15, 8'd14, 1'b0, 9});
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_div(tbl[i].a, tbl[i].b, 0, q, r, dz, e, bc);
            chk($sformatf("v%0d_q", i), q, tbl[i].q);
            chk($sformatf("v%0d_r", i), r, tbl[i].r);
            chk($sformatf("v%0d_dz", i), dz, tbl[i].dz);
            chk($sformatf("v%0d_lat", i), e, tbl[i].lat);
            chk($sformatf("v%0d_busy", i), bc, tbl[i].lat);
        end

        // start held through CALC and DONE: only one result.
        run_div(8'd100, 8'd3, 1, q, r, dz, e, bc);
        chk("hold_q", q, 33);
        chk("hold_r", r, 1);
        chk("hold_lat", e, 9);
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("hold_extra_done", nd, 0);

        // Divide-by-zero sets the flag so the reset check is meaningful.
        run_div(8'd37, 8'd0, 0, q, r, dz, e, bc);
        chk("dz_set", dz, 1);

        // Reset in the middle of a run aborts with no done.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_q", quotient, 0);
        chk("mid_r", remainder, 0);
        chk("mid_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("mid_no_done", nd, 0);
        run_div(8'd50, 8'd5, 0, q, r, dz, e, bc);
        chk("post_q", q, 10);
        chk("post_r", r, 0);
        chk("post_dz", dz, 0);

        // Random sweep against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] eq;
            logic [W-1:0] er;
            a = W'($urandom);
            b = (i % 25 == 0) ? '0 : W'($urandom);
            model(a, b, eq, er);
            run_div(a, b, 0, q, r, dz, e, bc);
            chk($sformatf("rnd%0d_q", i), q, eq);
            chk($sformatf("rnd%0d_r", i), r, er);
            chk($sformatf("rnd%0d_dz", i), dz, (b == '0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
